div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 35 +++
 rtl/div_iter.sv | 142 ++++++++++++++
 tb/tb_div_iter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the sizing rule for the step counter.
package div_pkg;

  // FSM state type and its encodings.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int unsigned DEF_DATAWIDTH = 8;

  // The counter must reach DATAWIDTH itself, hence the +1.
  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_DATAWIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   prem_i    partial remainder before the step (DATAWIDTH+1 bits)
//   dvd_bit_i next dividend bit, shifted into the partial remainder LSB
//   divisor_i divisor
//   prem_o    partial remainder after the step
//   qbit_o    quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic [DATAWIDTH:0]   prem_i,
  input  logic                 dvd_bit_i,
  input  logic [DATAWIDTH-1:0] divisor_i,
  output logic [DATAWIDTH:0]   prem_o,
  output logic                 qbit_o
);

  logic [DATAWIDTH:0] shifted_c;
  logic [DATAWIDTH:0] divisor_ext_c;
  logic [DATAWIDTH:0] diff_c;
  logic               ge_c;

  // The incoming remainder is always below the divisor, so its top bit is
  // zero and dropping it on the shift loses nothing.
  assign shifted_c     = (DATAWIDTH+1)'({prem_i, dvd_bit_i});
  assign divisor_ext_c = {1'b0, divisor_i};
  assign ge_c          = (shifted_c >= divisor_ext_c);
  assign diff_c        = shifted_c - divisor_ext_c;

  assign prem_o = ge_c ? diff_c : shifted_c;
  assign qbit_o = ge_c;

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   Clk   clock, rising edge
//   Rst   synchronous active-high reset
//   start request a divide (accepted when ready=1)
//   a, b  dividend / divisor, sampled with an accepted start
//   ready idle, start accepted
//   done  one-cycle pulse, quot/rem/dbz valid
//   quot  quotient a/b
//   rem   remainder a%b
//   dbz   completed divide had b==0
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 ready,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 dbz
);

  localparam int unsigned CntW = cnt_width(DATAWIDTH);

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [DATAWIDTH-1:0] dvs_q, dvs_d;
  logic [DATAWIDTH:0]   prem_q, prem_d;
  logic [DATAWIDTH-1:0] quot_q, quot_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic                 dbz_q, dbz_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic [DATAWIDTH:0]   step_prem_c;
  logic                 step_qbit_c;

  div_step #(
    .DATAWIDTH (DATAWIDTH)
  ) u_step (
    .prem_i    (prem_q),
    .dvd_bit_i (dvd_q[DATAWIDTH-1]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem_c),
    .qbit_o    (step_qbit_c)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          dvd_d   = a;
          dvs_d   = b;
          prem_d  = '0;
        end
      end
      ST_RUN: begin
        // The cycle after the last step publishes the result, which keeps
        // latency fixed at DATAWIDTH+1 edges after acceptance.
        if (cnt_q == CntW'(DATAWIDTH)) begin
          state_d = ST_DONE;
          quot_d  = dvd_q;
          rem_d   = prem_q[DATAWIDTH-1:0];
          dbz_d   = (dvs_q == '0);
        end else begin
          prem_d = step_prem_c;
          dvd_d  = (dvd_q << 1) | DATAWIDTH'(step_qbit_c);
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          dvd_d   = a;
          dvs_d   = b;
          prem_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d != ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign quot  = quot_q;
  assign rem   = rem_q;
  assign dbz   = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter (DATAWIDTH=8) with hand-computed vectors.
module tb_div_iter;

  localparam int unsigned DW = 8;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          ready;
  logic          done;
  logic [DW-1:0] quot;
  logic [DW-1:0] rem;
  logic          dbz;

  div_iter #(.DATAWIDTH(DW)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .quot  (quot),
    .rem   (rem),
    .dbz   (dbz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Edge counter: after rising edge k, cyc == k.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int    q;
    int    r;
    int    z;
    int    cyc;
    string tag;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_quot"}, int'(quot), e.q);
        chk({e.tag, "_rem"},  int'(rem),  e.r);
        chk({e.tag, "_dbz"},  int'(dbz),  e.z);
        chk({e.tag, "_lat"},  cyc,        e.cyc);
      end
    end
  end

  // Called at a negedge; accepting edge is the next posedge (cyc+1), so
  // done is expected at the negedge where cyc == accept + 9.
  task automatic issue(input int av, input int bv, input int q, input int r,
                       input int z, input string tag);
    exp_t e;
    chk({tag, "_ready"}, int'(ready), 1);
    a     = 8'(av);
    b     = 8'(bv);
    start = 1'b1;
    e.q   = q;
    e.r   = r;
    e.z   = z;
    e.cyc = cyc + 10;
    e.tag = tag;
    sb.push_back(e);
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high; ready must stay low until then.
  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        chk({tag, "_busy"}, int'(ready), 0);
        @(negedge Clk);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done in 40 cycles, expected done", tag);
    end
  endtask

  // Full divide plus a check that results hold while inputs wiggle.
  task automatic run(input int av, input int bv, input int q, input int r,
                     input int z, input string tag);
    issue(av, bv, q, r, z, tag);
    wait_done(tag);
    a = 8'hC3;
    b = 8'h00;
    @(negedge Clk);
    chk({tag, "_hold_quot"}, int'(quot), q);
    chk({tag, "_hold_rem"},  int'(rem),  r);
    chk({tag, "_hold_dbz"},  int'(dbz),  z);
  endtask

  initial begin : stim
    Rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk("rst_ready", int'(ready), 1);
    chk("rst_done",  int'(done),  0);
    chk("rst_quot",  int'(quot),  0);
    chk("rst_rem",   int'(rem),   0);
    chk("rst_dbz",   int'(dbz),   0);

    run(100,   7,  14,   2, 0, "d100_7");
    run(255,   1, 255,   0, 0, "d255_1");
    run(  3, 200,   0,   3, 0, "d3_200");
    run(  5,   0, 255,   5, 1, "d5_0");
    run(200, 200,   1,   0, 0, "d200_200");
    run(  0,   5,   0,   0, 0, "d0_5");
    run(250,  16,  15,  10, 0, "d250_16");
    run(128, 255,   0, 128, 0, "d128_255");

    // start while busy is ignored; operands changed after acceptance.
    issue(100, 7, 14, 2, 0, "busy");
    @(negedge Clk);
    chk("busy_ready_at_start", int'(ready), 0);
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd3;
    @(negedge Clk);
    start = 1'b0;
    a     = 8'hFF;
    b     = 8'h01;
    wait_done("busy");
    repeat (15) @(negedge Clk);

    // Back-to-back: new start in the DONE cycle.
    issue(100, 7, 14, 2, 0, "b2b_1");
    wait_done("b2b_1");
    issue(9, 3, 3, 0, 0, "b2b_2");
    wait_done("b2b_2");
    @(negedge Clk);

    // Abort with reset at accept+4; no done for the aborted divide.
    issue(100, 7, 14, 2, 0, "abort");
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    sb.delete(sb.size() - 1);
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_done",  int'(done),  0);
    chk("abort_quot",  int'(quot),  0);
    chk("abort_rem",   int'(rem),   0);
    chk("abort_dbz",   int'(dbz),   0);
    repeat (15) @(negedge Clk);
    run(100, 7, 14, 2, 0, "after_abort");

    repeat (3) @(negedge Clk);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
